// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing one-outstanding instruction fetches into the IF/ID register
module fetch_stage #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h13
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            Halt,
    input  logic            Stall,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] IfId_PC,
    output logic [31:0]     IfId_Instr,
    output logic            IfId_Valid,
    output logic            Halted
);
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALT} state_t;
    state_t state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d, skid_pc_q, skid_pc_d, ifid_pc_q, ifid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d, ifid_instr_q, ifid_instr_d;
    logic ifid_valid_q, ifid_valid_d, squash_q, squash_d, halted_q, halted_d, started_q;
    logic redirect, stop, accept, unused_bits;

    // Only the PC-width part of the redirect target is meaningful
    assign unused_bits = ^BrPC[31:PC_W];
    // A halt already taken overrides any later redirect
    assign redirect = PcSel & ~halted_q & (state_q != HALT);
    assign stop = Halt | halted_q;
    // started_q keeps the request low until the first edge after reset release
    assign imem_req = (state_q == FETCH) & started_q & ~Halt;
    assign accept = imem_req & imem_ready;
    assign imem_addr = pc_q;
    assign IfId_PC = ifid_pc_q;
    assign IfId_Instr = ifid_instr_q;
    assign IfId_Valid = ifid_valid_q;
    assign Halted = halted_q;

    // Next-state, PC and IF/ID update; a flush or a delivery overrides the stall/bubble default
    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        req_pc_d = req_pc_q;
        skid_pc_d = skid_pc_q;
        skid_instr_d = skid_instr_q;
        squash_d = squash_q;
        halted_d = halted_q | Halt;
        ifid_pc_d = ifid_pc_q;
        ifid_instr_d = Stall ? ifid_instr_q : NOP;
        ifid_valid_d = Stall & ifid_valid_q;
        if (redirect) pc_d = BrPC[PC_W-1:0] & ~PC_W'(3);
        if (Halt | redirect) begin
            ifid_instr_d = NOP;
            ifid_valid_d = 1'b0;
        end
        case (state_q)
            FETCH: begin
                if (Halt) state_d = HALT;
                else if (accept) begin
                    state_d = WAIT;
                    squash_d = redirect;
                    req_pc_d = pc_q;
                    if (!redirect) pc_d = pc_q + PC_W'(4);
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    squash_d = 1'b0;
                    state_d = stop ? HALT : FETCH;
                    if (!stop && !squash_q && !redirect) begin
                        if (Stall) begin
                            state_d = HOLD;
                            skid_pc_d = req_pc_q;
                            skid_instr_d = imem_rdata;
                        end else begin
                            ifid_pc_d = req_pc_q;
                            ifid_instr_d = imem_rdata;
                            ifid_valid_d = 1'b1;
                        end
                    end
                end else if (redirect) squash_d = 1'b1;
            end
            HOLD: begin
                if (Halt) state_d = HALT;
                else if (redirect) state_d = FETCH;
                else if (!Stall) begin
                    state_d = FETCH;
                    ifid_pc_d = skid_pc_q;
                    ifid_instr_d = skid_instr_q;
                    ifid_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q <= RESET_PC;
            req_pc_q <= '0;
            skid_pc_q <= '0;
            skid_instr_q <= NOP;
            ifid_pc_q <= '0;
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
            squash_q <= 1'b0;
            halted_q <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            req_pc_q <= req_pc_d;
            skid_pc_q <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            ifid_pc_q <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            squash_q <= squash_d;
            halted_q <= halted_d;
            started_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch traffic against a transaction-level scoreboard
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h13;
    logic clk = 1'b0, reset, PcSel, Halt, Stall, imem_ready, imem_rvalid;
    logic [31:0] BrPC, imem_rdata, IfId_Instr;
    logic imem_req, IfId_Valid, Halted;
    logic [8:0] imem_addr, IfId_PC;

    fetch_stage dut (
        .clk(clk), .reset(reset), .PcSel(PcSel), .BrPC(BrPC), .Halt(Halt), .Stall(Stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .IfId_PC(IfId_PC),
        .IfId_Instr(IfId_Instr), .IfId_Valid(IfId_Valid), .Halted(Halted)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0;
    logic [40:0] exp_q[$];
    logic last_stall = 1'b0, last_kill = 1'b0, halted_m = 1'b0;
    event tick;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: after each edge, compare IF/ID against the scoreboard
    logic [31:0] p_instr = NOP;
    logic [8:0] p_pc = '0;
    logic p_valid = 1'b0;
    always begin
        logic [40:0] e;
        @(tick);
        if (last_kill) begin
            chk("flush_valid", 32'(IfId_Valid), 0);
            chk("flush_instr", IfId_Instr, NOP);
        end else if (last_stall) begin
            chk("hold_valid", 32'(IfId_Valid), 32'(p_valid));
            chk("hold_instr", IfId_Instr, p_instr);
            chk("hold_pc", 32'(IfId_PC), 32'(p_pc));
        end else begin
            chk("ifid_valid", 32'(IfId_Valid), 32'(exp_q.size() != 0));
            if (IfId_Valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("ifid_pc", 32'(IfId_PC), 32'(e[40:32]));
                chk("ifid_instr", IfId_Instr, e[31:0]);
            end else if (!IfId_Valid) chk("bubble_instr", IfId_Instr, NOP);
        end
        chk("halted", 32'(Halted), 32'(halted_m));
        if (halted_m) chk("halted_no_req", 32'(imem_req), 0);
        p_instr = IfId_Instr;
        p_pc = IfId_PC;
        p_valid = IfId_Valid;
    end

    // Stimulus: reset scenarios, then random memory/redirect/stall traffic
    initial begin
        logic [8:0] exp_pc, out_addr, rsp_addr;
        logic s_req, acc, redir, kill, out_v;
        logic [8:0] s_addr;
        int epoch, out_tag, rsp_tag, out_cnt, n_acc, wraps;
        reset = 1; PcSel = 0; BrPC = 0; Halt = 0; Stall = 0;
        imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
        #1;
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_valid", 32'(IfId_Valid), 0);
        chk("rst_instr", IfId_Instr, NOP);
        chk("rst_pc", 32'(IfId_PC), 0);
        chk("rst_halted", 32'(Halted), 0);
        repeat (2) @(negedge clk);
        chk("rst_req_held", 32'(imem_req), 0);
        reset = 0; imem_ready = 1;
        @(negedge clk);
        chk("first_req", 32'(imem_req), 1);
        chk("first_addr", 32'(imem_addr), 0);
        @(negedge clk);
        chk("wait_no_req", 32'(imem_req), 0);
        reset = 1;
        #1 chk("midrst_req", 32'(imem_req), 0);
        @(negedge clk);
        reset = 0; imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        imem_rvalid = 0;
        chk("late_rsp_valid", 32'(IfId_Valid), 0);
        chk("late_rsp_instr", IfId_Instr, NOP);
        chk("refetch_req", 32'(imem_req), 1);
        chk("refetch_addr", 32'(imem_addr), 0);
        exp_pc = 0; out_v = 0; out_addr = 0; rsp_addr = 0;
        epoch = 0; out_tag = 0; rsp_tag = -1; out_cnt = 0; n_acc = 0; wraps = 0;
        for (int c = 0; c < 2700; c++) begin
            imem_ready = ($urandom_range(0, 9) < 7);
            Stall = ($urandom_range(0, 3) == 0);
            PcSel = ($urandom_range(0, 19) == 0);
            BrPC = $urandom;
            if ($urandom_range(0, 3) == 0) BrPC[8:4] = 5'h1F;
            Halt = (c == 2500);
            imem_rvalid = 0;
            if (out_v) begin
                out_cnt--;
                if (out_cnt == 0) begin
                    imem_rvalid = 1;
                    imem_rdata = $urandom;
                    rsp_tag = out_tag;
                    rsp_addr = out_addr;
                    out_v = 0;
                end
            end
            #1;
            s_req = imem_req;
            s_addr = imem_addr;
            @(negedge clk);
            acc = s_req && imem_ready;
            redir = PcSel && !halted_m;
            kill = redir || Halt;
            if (acc) begin
                chk("fetch_addr", 32'(s_addr), 32'(exp_pc));
                chk("one_outstanding", 32'(out_v), 0);
                out_v = 1; out_tag = epoch; out_addr = exp_pc;
                out_cnt = $urandom_range(1, 3);
                n_acc++;
            end
            if (redir) exp_pc = BrPC[8:0] & 9'h1FC;
            else if (acc) begin
                if (exp_pc == 9'h1FC) wraps++;
                exp_pc = exp_pc + 9'd4;
            end
            if (kill) begin
                epoch++;
                exp_q.delete();
            end
            if (Halt) halted_m = 1;
            if (imem_rvalid && rsp_tag == epoch) exp_q.push_back({rsp_addr, imem_rdata});
            last_stall = Stall;
            last_kill = kill;
            -> tick;
        end
        #1;
        chk("progress", 32'(n_acc > 200), 1);
        chk("pc_wrapped", 32'(wraps > 0), 1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
